sum: RTL and testbench

- PC incrementer for the rv32i single-cycle core: computes next sequential PC = pc_in + 4.
- Combinational result feeds the next-PC mux with zero latency.
- A registered copy with enable, plus a wrap flag, is provided for pipelined or debug consumers.
- One clock domain; asynchronous active-high reset affects only the registered outputs.

---
 rtl/sum.sv | 50 +++++
 tb/tb_sum.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sum.sv
// PC incrementer for the rv32i single-cycle core.
// The combinational pc_in + STEP feeds the next-PC mux with zero latency.
// A registered copy of the sum and its carry-out is kept for pipelined or
// debug consumers. Only the registered copy is affected by reset.
module sum #(
  parameter int unsigned           WIDTH    = 32,
  // Increment applied to pc_in; must be less than 2**WIDTH.
  parameter int unsigned           STEP     = 4,
  parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_out,
  output logic             wrap,
  output logic [WIDTH-1:0] pc_q,
  output logic             wrap_q
);

  // The step is widened by one bit so the carry-out lands in the MSB of the sum.
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] pc_d;
  logic             wrap_d;

  // Full-width add: the low WIDTH bits are the next PC, the top bit is the wrap flag.
  always_comb begin
    sum_full = {1'b0, pc_in} + STEP_EXT;
    pc_out   = sum_full[WIDTH-1:0];
    wrap     = sum_full[WIDTH];
    pc_d     = pc_out;
    wrap_d   = wrap;
  end

  // Registered copy of the sum; async reset clears it, en gates the capture.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: Sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of statement order.
    if (rst) begin
      pc_q   <= RESET_PC;
      wrap_q <= 1'b0;
    end else if (en) begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: tb/tb_sum.sv
// Directed and swept checks for the PC incrementer: combinational sum and
// wrap flag, enabled capture, hold, and asynchronous reset of the registers.
module tb_sum;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic        wrap;
  logic [31:0] pc_q;
  logic        wrap_q;

  int n_vec;
  int n_err;

  sum #(
    .WIDTH   (32),
    .STEP    (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .pc_in (pc_in),
    .pc_out(pc_out),
    .wrap  (wrap),
    .pc_q  (pc_q),
    .wrap_q(wrap_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Directed combinational vectors: pc_in, expected pc_out, expected wrap.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_pc;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[6];

  logic [31:0] rnd;
  logic        rnd_en;
  logic [31:0] model_pc_q;
  logic        model_wrap_q;

  initial begin
    n_vec = 0;
    n_err = 0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h0000_0008, 1'b0};
    vecs[2] = '{32'h0000_000C, 32'h0000_0010, 1'b0};
    vecs[3] = '{32'h0000_0002, 32'h0000_0006, 1'b0};
    vecs[4] = '{32'hFFFF_FFFD, 32'h0000_0001, 1'b1};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

    // Reset state, with the combinational path still live during reset.
    rst   = 1'b1;
    en    = 1'b1;
    pc_in = 32'h0000_0010;
    #2;
    check("reset pc_q", pc_q, 32'h0000_0000);
    check("reset wrap_q", {31'b0, wrap_q}, 32'h0);
    check("comb during reset", pc_out, 32'h0000_0014);
    @(posedge clk);
    #1;
    check("pc_q held in reset across edge", pc_q, 32'h0000_0000);

    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    // Combinational vectors, each held for a full clock period.
    for (int i = 0; i < 6; i++) begin
      pc_in = vecs[i].pc;
      #10;
      check($sformatf("pc_out vec%0d", i), pc_out, vecs[i].exp_pc);
      check($sformatf("wrap vec%0d", i), {31'b0, wrap}, {31'b0, vecs[i].exp_wrap});
    end

    // Capture the wrap-around sum.
    @(negedge clk);
    pc_in = 32'hFFFF_FFFC;
    en    = 1'b1;
    @(posedge clk);
    #1;
    check("capture FFFFFFFC pc_q", pc_q, 32'h0000_0000);
    check("capture FFFFFFFC wrap_q", {31'b0, wrap_q}, 32'h1);

    // Capture a non-zero wrapped value so the reset below moves both registers.
    @(negedge clk);
    pc_in = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    check("capture FFFFFFFD pc_q", pc_q, 32'h0000_0001);
    check("capture FFFFFFFD wrap_q", {31'b0, wrap_q}, 32'h1);

    // Reset asserted mid-cycle takes effect before any clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async reset pc_q", pc_q, 32'h0000_0000);
    check("async reset wrap_q", {31'b0, wrap_q}, 32'h0);
    @(posedge clk);
    #1;
    check("reset overrides en pc_q", pc_q, 32'h0000_0000);
    check("reset overrides en wrap_q", {31'b0, wrap_q}, 32'h0);

    // First enabled edge after release captures the current sum.
    @(negedge clk);
    rst   = 1'b0;
    pc_in = 32'h0000_0100;
    en    = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset capture pc_q", pc_q, 32'h0000_0104);
    check("post-reset capture wrap_q", {31'b0, wrap_q}, 32'h0);

    // Hold with en low across two edges while the combinational path moves on.
    @(negedge clk);
    en    = 1'b0;
    pc_in = 32'h0000_0200;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("hold pc_q", pc_q, 32'h0000_0104);
    check("hold wrap_q", {31'b0, wrap_q}, 32'h0);
    check("hold pc_out", pc_out, 32'h0000_0204);

    // Sweep: random pc_in with random enable, top-of-range values mixed in.
    model_pc_q   = 32'h0000_0104;
    model_wrap_q = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      rnd = $urandom;
      if (i % 50 == 0) rnd = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      if (i % 50 == 1) rnd = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
      rnd_en = 1'($urandom_range(0, 1));
      pc_in  = rnd;
      en     = rnd_en;
      #1;
      check("sweep pc_out", pc_out, rnd + 32'd4);
      check("sweep wrap", {31'b0, wrap}, {31'b0, (rnd >= 32'hFFFF_FFFC)});
      if (rnd_en) begin
        model_pc_q   = rnd + 32'd4;
        model_wrap_q = (rnd >= 32'hFFFF_FFFC);
      end
      @(posedge clk);
      #1;
      check("sweep pc_q", pc_q, model_pc_q);
      check("sweep wrap_q", {31'b0, wrap_q}, {31'b0, model_wrap_q});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
